// File: rtl/johnson_seq_decoder.sv
// Receive-side decoder for a 5-bit Johnson (twisted-ring) counter stream.
// Decodes each sampled word to 0..9, tracks succession, holds lock and counts errors.
module johnson_seq_decoder #(
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [4:0]       code,
  input  logic             clear_err,
  output logic [3:0]       idx,
  output logic             idx_valid,
  output logic             code_err,
  output logic             seq_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  // Handshake: code_valid is a one-way strobe with no backpressure; a word is
  // consumed on every rising edge where code_valid=1, and all responses appear
  // registered one edge later as single-cycle pulses (idx/locked/err_count are levels).

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] prev, prev_n;
  logic [3:0] good_cnt, good_n;

  logic [3:0] idx_n;
  logic       idx_valid_n, code_err_n, seq_err_n, wrap_n;
  logic       err_inc;

  logic       legal;
  logic [3:0] dec;
  logic [3:0] succ;
  logic       is_succ;

  always_comb begin
    legal = 1'b1;
    dec   = 4'd0;
    unique case (code)
      5'b00000: dec = 4'd0;
      5'b00001: dec = 4'd1;
      5'b00011: dec = 4'd2;
      5'b00111: dec = 4'd3;
      5'b01111: dec = 4'd4;
      5'b11111: dec = 4'd5;
      5'b11110: dec = 4'd6;
      5'b11100: dec = 4'd7;
      5'b11000: dec = 4'd8;
      5'b10000: dec = 4'd9;
      default:  legal = 1'b0;
    endcase
  end

  assign succ    = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
  assign is_succ = (dec == succ);

  always_comb begin
    state_n     = state;
    prev_n      = prev;
    good_n      = good_cnt;
    idx_n       = idx;
    idx_valid_n = 1'b0;
    code_err_n  = 1'b0;
    seq_err_n   = 1'b0;
    wrap_n      = 1'b0;
    err_inc     = 1'b0;
    if (code_valid) begin
      if (!legal) begin
        // Any illegal word drops back to hunting; prev is left as it was.
        code_err_n = 1'b1;
        idx_n      = 4'hF;
        err_inc    = 1'b1;
        state_n    = HUNT;
        good_n     = 4'd0;
      end else begin
        idx_n       = dec;
        idx_valid_n = 1'b1;
        prev_n      = dec;
        unique case (state)
          HUNT: begin
            good_n  = 4'd0;
            state_n = TRACK;
          end
          TRACK: begin
            if (is_succ) begin
              if (good_cnt + 4'd1 == 4'(LOCK_LEN)) begin
                state_n = LOCKED;
                good_n  = 4'd0;
              end else begin
                good_n = good_cnt + 4'd1;
              end
            end else begin
              good_n = 4'd0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              wrap_n = (prev == 4'd9);
            end else begin
              seq_err_n = 1'b1;
              err_inc   = 1'b1;
              state_n   = TRACK;
              good_n    = 4'd0;
            end
          end
          default: begin
            state_n = HUNT;
            good_n  = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      prev      <= 4'd0;
      good_cnt  <= 4'd0;
      idx       <= 4'd0;
      idx_valid <= 1'b0;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      good_cnt  <= good_n;
      idx       <= idx_n;
      idx_valid <= idx_valid_n;
      code_err  <= code_err_n;
      seq_err   <= seq_err_n;
      wrap      <= wrap_n;
    end
  end

  assign locked = (state == LOCKED);

  // clear_err wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clear_err) begin
      err_count <= '0;
    end else if (err_inc && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
